main_stream_egress: RTL and testbench
=====================================

Name: main_stream_egress

Overview:
- Output-side counterpart of the kernel stream wrapper.
- Accepts one FloPoCo-format result stream from the kernel: {2-bit exception field, 32-bit word}.
- Decodes the exception field back to a legal IEEE-754 single, buffers words in a small FIFO, and presents a valid/ready stream to the host shell.
- Keeps saturating counters of infinity and NaN results for debug readback.

Parameters:
- STREAMW, 32: IEEE word width. Only 32 is supported; the input width is STREAMW+2.
- DEPTH, 4: FIFO depth. Must be a power of two and at least 2.
- CNTW, 16: width of the exception counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ivalid  in  1  kernel result valid.
- iready  out  1  egress can accept a word.
- fpc_in  in  STREAMW+2  FloPoCo word. [33:32] is the exception field, [31] the sign, [30:0] the exponent and mantissa.
- ovalid  out  1  data_out valid.
- oready  in  1  host consumes data_out.
- data_out  out  STREAMW  IEEE-754 single.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- clr_cnt  in  1  synchronous clear of both counters.
- inf_cnt  out  CNTW  number of accepted words with exception field 10.
- nan_cnt  out  CNTW  number of accepted words with exception field 11.

Behaviour:
- Reset (rst low, asynchronous assert, synchronous-safe deassert):
  - FIFO pointers and level = 0, so ovalid = 0 and iready = 1.
  - data_out = 0; inf_cnt and nan_cnt = 0.
  - Asserting reset mid-transfer discards all buffered words, with no output glitch beyond going invalid.
- Push: a word is accepted on a rising edge where ivalid && iready. iready = (level < DEPTH), taken from registered state only (no combinational path from oready).
- Pop: occurs on a rising edge where ovalid && oready. ovalid = (level != 0). data_out is always the FIFO head and holds stable while ovalid && !oready.
- Latency: a word accepted at edge N is visible on data_out with ovalid = 1 after edge N (one cycle). There is no flow-through when the FIFO is empty.
- Simultaneous push and pop:
  - When 0 < level < DEPTH, level is unchanged and both pointers advance.
  - When full, iready = 0, so only the pop happens; iready rises the next cycle.
  - When empty, only the push happens.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. level increments on push-only and decrements on pop-only.
- Conversion is applied at write time, so stored words are already IEEE:
  - 00 (zero): {sign, 31'b0}; signed zero is preserved.
  - 01 (normal): fpc_in[31:0] passes through unchanged.
  - 10 (infinity): {sign, 8'hFF, 23'b0}.
  - 11 (NaN): canonical 32'h7FC00000; sign and payload are dropped.
- Counters:
  - Increment only on an accepted push with exception 10 (inf_cnt) or 11 (nan_cnt).
  - Saturate at all-ones.
  - clr_cnt has priority over an increment in the same cycle; the result is 0.
- No other state machine. Control is the FIFO's implicit state set: EMPTY (level=0), PARTIAL, FULL (level=DEPTH).

Decomposition:
- Shared package main_fpc_pkg:
  - exception-code constants FPC_ZERO = 2'b00, FPC_NORMAL = 2'b01, FPC_INF = 2'b10, FPC_NAN = 2'b11.
  - IEEE_QNAN = 32'h7FC00000.
  - EXP_ALL1 = 8'hFF.
  - These are also used by the ingress side that appends the exception field.
- One combinational sub-module, main_fpc2ieee: {exc, word} in, 32-bit IEEE word out. It is reused by any future multi-lane egress.
- The FIFO and counters live in the top module.

Test Plan:
- Reset and basic pass-through:
  - Release rst.
  - Push {01, 32'h3F800000} with oready = 1.
  - Required: data_out = 32'h3F800000 and ovalid = 1 one cycle after acceptance; level returns to 0 after the pop.
- Exception decode:
  - Push {00, 32'h80001234}, {10, 32'h00000001}, {11, 32'h80ABCDEF}, {10, 32'h80000000}.
  - Required outputs in order: 32'h80000000, 32'h7F800000, 32'h7FC00000, 32'hFF800000.
  - Required counters: inf_cnt = 2, nan_cnt = 1.
- Backpressure and full:
  - Hold oready = 0 and push 5 words with ivalid held high.
  - Required: iready falls after the 4th acceptance; level = 4; data_out holds word 0.
  - Raise oready: words 0 to 4 emerge in order with no loss or duplication.
- Simultaneous push and pop:
  - With level = 2, drive ivalid = oready = 1 for 10 cycles.
  - Required: level stays 2; the output sequence matches the input order.
- Counter saturation and clear:
  - Preload via 65535+3 NaN pushes (CNTW = 16); require nan_cnt = 16'hFFFF.
  - Assert clr_cnt coincident with a NaN push; require nan_cnt = 0 on the next cycle.
- Reset mid-operation:
  - With level = 3, pulse rst low asynchronously, between clock edges.
  - Required: ovalid = 0, level = 0, iready = 1 and counters = 0 immediately.
  - After release, the first pushed word appears first.

Source files
------------

// File: rtl/main_fpc_pkg.sv
// FloPoCo exception-field encoding shared by the stream ingress and egress.
// The 2-bit field sits above a 32-bit word: {exc, sign, exp, mant}.
package main_fpc_pkg;

    localparam logic [1:0] FPC_ZERO   = 2'b00;
    localparam logic [1:0] FPC_NORMAL = 2'b01;
    localparam logic [1:0] FPC_INF    = 2'b10;
    localparam logic [1:0] FPC_NAN    = 2'b11;

    localparam logic [31:0] IEEE_QNAN = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_ALL1  = 8'hFF;

endpackage

// File: rtl/main_fpc2ieee.sv
// FloPoCo {exc, word} to IEEE-754 single, purely combinational.
// NaNs collapse to the canonical quiet NaN; zero and infinity keep the sign.
module main_fpc2ieee
    import main_fpc_pkg::*;
(
    input  logic [1:0]  exc_i,
    input  logic [31:0] word_i,
    output logic [31:0] ieee_o
);

    always_comb begin
        ieee_o = word_i;
        unique case (exc_i)
            FPC_ZERO:   ieee_o = {word_i[31], 31'b0};
            FPC_NORMAL: ieee_o = word_i;
            FPC_INF:    ieee_o = {word_i[31], EXP_ALL1, 23'b0};
            FPC_NAN:    ieee_o = IEEE_QNAN;
        endcase
    end

endmodule

// File: rtl/main_stream_egress.sv
// Kernel result egress: FloPoCo decode, small FIFO, valid/ready to the host,
// plus saturating infinity/NaN counters for debug readback.
module main_stream_egress
    import main_fpc_pkg::*;
#(
    parameter int STREAMW = 32,
    parameter int DEPTH   = 4,
    parameter int CNTW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ivalid,
    output logic                     iready,
    input  logic [STREAMW+1:0]       fpc_in,
    output logic                     ovalid,
    input  logic                     oready,
    output logic [STREAMW-1:0]       data_out,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     clr_cnt,
    output logic [CNTW-1:0]          inf_cnt,
    output logic [CNTW-1:0]          nan_cnt
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]     LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;

    logic [STREAMW-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        level_q, level_d;
    logic [CNTW-1:0]    inf_cnt_q, inf_cnt_d;
    logic [CNTW-1:0]    nan_cnt_q, nan_cnt_d;

    logic [1:0]         exc;
    logic [31:0]        ieee_word;
    logic               push, pop;

    assign exc = fpc_in[STREAMW+1:STREAMW];

    main_fpc2ieee u_fpc2ieee (
        .exc_i  (exc),
        .word_i (fpc_in[31:0]),
        .ieee_o (ieee_word)
    );

    // Handshakes depend on registered occupancy only.
    assign iready = (level_q != LVL_FULL);
    assign ovalid = (level_q != '0);
    assign push   = ivalid && iready;
    assign pop    = ovalid && oready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        inf_cnt_d = inf_cnt_q;
        nan_cnt_d = nan_cnt_q;
        if (clr_cnt) begin
            inf_cnt_d = '0;
            nan_cnt_d = '0;
        end else if (push) begin
            if (exc == FPC_INF && inf_cnt_q != CNT_MAX)
                inf_cnt_d = inf_cnt_q + CNT_ONE;
            if (exc == FPC_NAN && nan_cnt_q != CNT_MAX)
                nan_cnt_d = nan_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            inf_cnt_q <= '0;
            nan_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            inf_cnt_q <= inf_cnt_d;
            nan_cnt_q <= nan_cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted in level.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ieee_word;
    end

    assign data_out = ovalid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;
    assign inf_cnt  = inf_cnt_q;
    assign nan_cnt  = nan_cnt_q;

endmodule

// File: tb/tb_main_stream_egress.sv
// Directed bench for main_stream_egress: decode, backpressure, overlap,
// counter saturation/clear and asynchronous reset.
module tb_main_stream_egress;

    logic        clk;
    logic        rst;
    logic        ivalid;
    logic        iready;
    logic [33:0] fpc_in;
    logic        ovalid;
    logic        oready;
    logic [31:0] data_out;
    logic [2:0]  level;
    logic        clr_cnt;
    logic [15:0] inf_cnt;
    logic [15:0] nan_cnt;

    int n_cmp = 0;
    int n_err = 0;

    main_stream_egress #(
        .STREAMW (32),
        .DEPTH   (4),
        .CNTW    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ivalid   (ivalid),
        .iready   (iready),
        .fpc_in   (fpc_in),
        .ovalid   (ovalid),
        .oready   (oready),
        .data_out (data_out),
        .level    (level),
        .clr_cnt  (clr_cnt),
        .inf_cnt  (inf_cnt),
        .nan_cnt  (nan_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [33:0] dec_in  [4];
    logic [31:0] dec_out [4];
    logic [31:0] w       [5];
    logic [31:0] a       [12];
    logic        acc;

    initial begin
        dec_in[0]  = {2'b00, 32'h8000_1234};
        dec_in[1]  = {2'b10, 32'h0000_0001};
        dec_in[2]  = {2'b11, 32'h80AB_CDEF};
        dec_in[3]  = {2'b10, 32'h8000_0000};
        dec_out[0] = 32'h8000_0000;
        dec_out[1] = 32'h7F80_0000;
        dec_out[2] = 32'h7FC0_0000;
        dec_out[3] = 32'hFF80_0000;
        for (int i = 0; i < 5; i++)  w[i] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i < 12; i++) a[i] = 32'h4000_0000 + 32'(i * 3);

        rst     = 1'b0;
        ivalid  = 1'b0;
        oready  = 1'b0;
        clr_cnt = 1'b0;
        fpc_in  = '0;
        step();
        step();
        chk("rst_ovalid", 32'(ovalid), 32'd0);
        chk("rst_iready", 32'(iready), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_inf", 32'(inf_cnt), 32'd0);
        chk("rst_nan", 32'(nan_cnt), 32'd0);
        rst = 1'b1;
        step();

        // Basic pass-through, one-cycle latency.
        ivalid = 1'b1;
        oready = 1'b1;
        fpc_in = {2'b01, 32'h3F80_0000};
        chk("pt_no_flow", 32'(ovalid), 32'd0);
        step();
        ivalid = 1'b0;
        chk("pt_ovalid", 32'(ovalid), 32'd1);
        chk("pt_data", data_out, 32'h3F80_0000);
        chk("pt_level1", 32'(level), 32'd1);
        step();
        chk("pt_level0", 32'(level), 32'd0);
        chk("pt_ovalid0", 32'(ovalid), 32'd0);

        // Exception decode.
        oready = 1'b0;
        ivalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fpc_in = dec_in[i];
            step();
        end
        ivalid = 1'b0;
        chk("dec_inf_cnt", 32'(inf_cnt), 32'd2);
        chk("dec_nan_cnt", 32'(nan_cnt), 32'd1);
        oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dec_out%0d", i), data_out, dec_out[i]);
            step();
        end
        chk("dec_drained", 32'(level), 32'd0);
        oready = 1'b0;

        // Backpressure and full.
        ivalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fpc_in = {2'b01, w[i]};
            step();
        end
        chk("full_iready", 32'(iready), 32'd0);
        chk("full_level", 32'(level), 32'd4);
        chk("full_head", data_out, w[0]);
        fpc_in = {2'b01, w[4]};
        step();
        step();
        chk("full_hold_lvl", 32'(level), 32'd4);
        chk("full_hold_data", data_out, w[0]);
        oready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("bp_out%0d", j), data_out, w[j]);
            chk($sformatf("bp_ov%0d", j), 32'(ovalid), 32'd1);
            acc = ivalid && iready;
            step();
            if (acc) ivalid = 1'b0;
            if (j == 0) chk("bp_iready_up", 32'(iready), 32'd1);
        end
        chk("bp_drained", 32'(level), 32'd0);
        chk("bp_in_taken", 32'(ivalid), 32'd0);

        // Simultaneous push and pop at level 2.
        oready = 1'b0;
        ivalid = 1'b1;
        fpc_in = {2'b01, a[0]};
        step();
        fpc_in = {2'b01, a[1]};
        step();
        chk("ov_level2", 32'(level), 32'd2);
        oready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fpc_in = {2'b01, a[i+2]};
            chk($sformatf("ov_out%0d", i), data_out, a[i]);
            step();
            chk($sformatf("ov_lvl%0d", i), 32'(level), 32'd2);
        end
        ivalid = 1'b0;
        chk("ov_tail0", data_out, a[10]);
        step();
        chk("ov_tail1", data_out, a[11]);
        step();
        chk("ov_empty", 32'(level), 32'd0);

        // NaN counter saturation, then clear beats a same-cycle increment.
        ivalid = 1'b1;
        oready = 1'b1;
        fpc_in = {2'b11, 32'h0000_0000};
        repeat (65538) step();
        chk("sat_nan", 32'(nan_cnt), 32'h0000_FFFF);
        chk("sat_inf_kept", 32'(inf_cnt), 32'd2);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        ivalid  = 1'b0;
        chk("clr_nan", 32'(nan_cnt), 32'd0);
        chk("clr_inf", 32'(inf_cnt), 32'd0);
        chk("clr_qnan_out", data_out, 32'h7FC0_0000);
        step();
        chk("clr_drained", 32'(level), 32'd0);

        // Asynchronous reset with three words buffered.
        oready = 1'b0;
        ivalid = 1'b1;
        fpc_in = {2'b10, 32'h0000_0000};
        step();
        fpc_in = {2'b01, 32'h1111_1111};
        step();
        fpc_in = {2'b01, 32'h2222_2222};
        step();
        ivalid = 1'b0;
        chk("mr_level3", 32'(level), 32'd3);
        chk("mr_inf1", 32'(inf_cnt), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_ovalid", 32'(ovalid), 32'd0);
        chk("mr_level", 32'(level), 32'd0);
        chk("mr_iready", 32'(iready), 32'd1);
        chk("mr_inf", 32'(inf_cnt), 32'd0);
        chk("mr_nan", 32'(nan_cnt), 32'd0);
        chk("mr_data", data_out, 32'd0);
        step();
        rst = 1'b1;
        step();
        ivalid = 1'b1;
        fpc_in = {2'b01, 32'hCAFE_0001};
        step();
        fpc_in = {2'b01, 32'hCAFE_0002};
        step();
        ivalid = 1'b0;
        chk("mr_first", data_out, 32'hCAFE_0001);
        chk("mr_lvl2", 32'(level), 32'd2);
        oready = 1'b1;
        step();
        chk("mr_second", data_out, 32'hCAFE_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
